// File: rtl/div_iter.sv
// Multi-cycle restoring divider, signed/unsigned, one quotient bit per clock.
// Optional macro DIV_ZERO_FLAG_EN adds the divzero_o flag output.
module div_iter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
`ifdef DIV_ZERO_FLAG_EN
    output logic                  divzero_o,
`endif
    output logic                  ready_o
);

    // state  | meaning
    // FREE   | idle, waiting for start_i
    // BYZERO | divisor was zero; two-cycle wait, then END with a zero result
    // ON     | one restoring step per clock; final cycle applies the sign fix
    // END    | first cycle raises ready_o, then holds until start_i drops
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   dsr;
    logic                neg_q;
    logic                neg_r;
`ifdef DIV_ZERO_FLAG_EN
    logic                zero_op;
`endif

    logic [DATA_W+1:0]   diff;
    logic [DATA_W-1:0]   abs1;
    logic [DATA_W-1:0]   abs2;

    // Quotient register starts as the dividend; its MSB feeds the partial remainder.
    assign diff = {1'b0, rem, quo[DATA_W-1]} - {2'b00, dsr};
    assign abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dsr      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= '0;
`ifdef DIV_ZERO_FLAG_EN
            zero_op   <= 1'b0;
            divzero_o <= 1'b0;
`endif
        end else begin
            case (state)
                FREE: begin
                    if (start_i && !annul_i) begin
                        cnt   <= '0;
                        rem   <= '0;
                        quo   <= abs1;
                        dsr   <= abs2;
                        neg_q <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_r <= signed_div_i & opdata1_i[DATA_W-1];
`ifdef DIV_ZERO_FLAG_EN
                        zero_op <= (opdata2_i == '0);
`endif
                        state <= (opdata2_i == '0) ? BYZERO : ON;
                    end
                end
                BYZERO: begin
                    rem   <= '0;
                    quo   <= '0;
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                    if (cnt == '0) cnt <= CNT_W'(1);
                    else           state <= END;
                end
                ON: begin
                    if (annul_i) begin
                        cnt   <= '0;
                        state <= FREE;
                    end else if (cnt == CNT_W'(DATA_W)) begin
                        quo   <= neg_q ? -quo : quo;
                        rem   <= neg_r ? -rem : rem;
                        state <= END;
                    end else begin
                        if (diff[DATA_W+1]) begin
                            rem <= {rem[DATA_W-2:0], quo[DATA_W-1]};
                            quo <= {quo[DATA_W-2:0], 1'b0};
                        end else begin
                            rem <= diff[DATA_W-1:0];
                            quo <= {quo[DATA_W-2:0], 1'b1};
                        end
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                END: begin
                    if (!ready_o) begin
                        ready_o  <= 1'b1;
                        result_o <= {rem, quo};
`ifdef DIV_ZERO_FLAG_EN
                        divzero_o <= zero_op;
`endif
                    end else if (!start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
`ifdef DIV_ZERO_FLAG_EN
                        divzero_o <= 1'b0;
`endif
                        state    <= FREE;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: vector table plus annul, reset and hold sequences.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        sgn, start, annul;
    logic [31:0] a, b;
    logic [63:0] result;
    logic        ready;
    logic        sgn8, start8;
    logic [7:0]  a8, b8;
    logic [15:0] result8;
    logic        ready8;
`ifdef DIV_ZERO_FLAG_EN
    logic        divzero, divzero8;
`endif

    always #5 clk = ~clk;

    div_iter #(.DATA_W(32), .CNT_W(7)) u_dut (
        .clk(clk), .rst(rst), .signed_div_i(sgn), .opdata1_i(a), .opdata2_i(b),
        .start_i(start), .annul_i(annul), .result_o(result),
`ifdef DIV_ZERO_FLAG_EN
        .divzero_o(divzero),
`endif
        .ready_o(ready)
    );

    div_iter #(.DATA_W(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .signed_div_i(sgn8), .opdata1_i(a8), .opdata2_i(b8),
        .start_i(start8), .annul_i(1'b0), .result_o(result8),
`ifdef DIV_ZERO_FLAG_EN
        .divzero_o(divzero8),
`endif
        .ready_o(ready8)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[12];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int n;
        sgn = v.sgn; a = v.a; b = v.b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(v.lat));
        check({tag, " result"}, result, {v.r, v.q});
`ifdef DIV_ZERO_FLAG_EN
        check({tag, " divzero"}, 64'(divzero), 64'(v.b == 32'd0));
`endif
        @(posedge clk); #1;
        check({tag, " exit ready"}, 64'(ready), 64'd0);
        check({tag, " exit result"}, result, 64'd0);
    endtask

    task automatic run8(input logic s, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] q, input logic [7:0] r, input string tag);
        int n;
        sgn8 = s; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 0;
        while (!ready8 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd10);
        check({tag, " result"}, 64'(result8), 64'({r, q}));
        @(posedge clk); #1;
        check({tag, " exit ready"}, 64'(ready8), 64'd0);
    endtask

    initial begin
        int n;
        logic seen;
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          34};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   34};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          34};
        vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          34};
        vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd0,          3};
        vecs[5]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   34};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          34};
        vecs[7]  = '{1'b0, 32'd9,          32'd4,          32'd2,          32'd1,          34};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   34};
        vecs[9]  = '{1'b0, 32'h80000000,   32'h10,         32'h08000000,   32'd0,          34};
        vecs[10] = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'd0,          32'd0,          3};
        vecs[11] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          34};

        rst = 1'b1; sgn = 0; a = 0; b = 0; start = 0; annul = 0;
        sgn8 = 0; a8 = 0; b8 = 0; start8 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset ready", 64'(ready), 64'd0);
        check("reset result", result, 64'd0);

        for (int i = 0; i < 12; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        run8(1'b0, 8'd200, 8'd3, 8'd66, 8'd2, "w8 200/3");
        run8(1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, "w8 min/-1");

        // annul on the 5th ON cycle
        sgn = 0; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready) seen = 1'b1;
        end
        check("annul no ready", 64'(seen), 64'd0);
        check("annul result", result, 64'd0);
        run_op(vecs[7], "after annul");

        // reset mid-division
        sgn = 0; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst ready", 64'(ready), 64'd0);
        check("midrst result", result, 64'd0);
        rst = 1'b0;
        run_op(vecs[7], "after rst");

        // start held through ON and END with changing operands
        sgn = 0; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        a = 32'd5; b = 32'd1; sgn = 1'b1;
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("hold latency", 64'(n), 64'd34);
        check("hold result", result, {32'd2, 32'd14});
        for (int i = 0; i < 4; i++) begin
            a = 32'h1234 + 32'(i); b = 32'(i); sgn = i[0]; annul = i[1];
            @(posedge clk); #1;
            check($sformatf("hold ready %0d", i), 64'(ready), 64'd1);
            check($sformatf("hold stable %0d", i), result, {32'd2, 32'd14});
        end
        annul = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check("hold exit ready", 64'(ready), 64'd0);
        check("hold exit result", result, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
